// File: rtl/modmul_arbiter.sv
// Round-robin front end for one shared fixed-latency modular multiplier.
// A requester tag travels alongside each product so the result returns to its issuer.
module modmul_arbiter #(
    parameter int data_width  = 14,
    parameter int num_req     = 4,
    parameter int mul_latency = 4,
    parameter int id_width    = $clog2(num_req)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_req-1:0]            req_valid,
    input  logic [num_req*data_width-1:0] req_a,
    input  logic [num_req*data_width-1:0] req_b,
    output logic [num_req-1:0]            req_ready,
    input  logic                          hold,
    output logic [data_width-1:0]         mul_a,
    output logic [data_width-1:0]         mul_b,
    input  logic [data_width-1:0]         mul_p,
    output logic [num_req-1:0]            resp_valid,
    output logic [data_width-1:0]         resp_data,
    output logic [2:0]                    inflight
);

    typedef struct packed {
        logic                valid;
        logic [id_width-1:0] id;
    } tag_t;

    logic                grant_any;
    logic [id_width-1:0] grant_id;
    logic [id_width-1:0] scan_id;
    logic [id_width-1:0] ptr_q, ptr_d;
    logic [2:0]          inflight_q, inflight_d;
    logic                resp_fire;
    tag_t                tag_q [mul_latency];

    // Search upward from ptr with wrap; the first valid requester wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        grant_any = 1'b0;
        grant_id  = '0;
        scan_id   = '0;
        for (int i = 0; i < num_req; i++) begin
            scan_id = id_width'((int'(ptr_q) + i) % num_req);
            if (!grant_any && req_valid[scan_id]) begin
                grant_any = 1'b1;
                grant_id  = scan_id;
            end
        end
        if (hold || rst) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
            mul_a = req_a[grant_id*data_width +: data_width];
            mul_b = req_b[grant_id*data_width +: data_width];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_id == id_width'(num_req - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    assign resp_fire = tag_q[mul_latency-1].valid;

    always_comb begin
        inflight_d = inflight_q;
        if (grant_any && !resp_fire) begin
            inflight_d = inflight_q + 3'd1;
        end else if (!grant_any && resp_fire) begin
            inflight_d = inflight_q - 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the tag shift reads last cycle's values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            inflight_q <= '0;
            // NOTE: every tag stage is cleared so a reset mid-flight never releases a stale strobe.
            for (int k = 0; k < mul_latency; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            tag_q[0]   <= '{valid: grant_any, id: grant_id};
            for (int k = 1; k < mul_latency; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // The last tag stage lines up with mul_p; both come straight from flops.
    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        if (tag_q[mul_latency-1].valid) begin
            resp_valid[tag_q[mul_latency-1].id] = 1'b1;
            resp_data = mul_p;
        end
    end

    assign inflight = inflight_q;

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed bench for modmul_arbiter with a 4-stage Barrett multiplier model and a response scoreboard.
module tb_modmul_arbiter;

    localparam int DW  = 14;
    localparam int NR  = 4;
    localparam int LAT = 4;
    localparam int Q   = 12289;

    typedef struct {
        int id;
        int data;
        int due;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              hold;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [NR*DW-1:0]  req_a;
    logic [NR*DW-1:0]  req_b;
    logic [DW-1:0]     mul_a;
    logic [DW-1:0]     mul_b;
    logic [DW-1:0]     mul_p;
    logic [DW-1:0]     resp_data;
    logic [2:0]        inflight;
    logic [DW-1:0]     mpipe [LAT];

    exp_t sb[$];
    int   issue_log[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   ptr_m    = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    modmul_arbiter #(
        .data_width (DW),
        .num_req    (NR),
        .mul_latency(LAT),
        .id_width   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .hold      (hold),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int modmul(input int a, input int b);
        return (a * b) % Q;
    endfunction

    // Shared multiplier model: LAT edges from operands to mul_p, cleared by the same reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) mpipe[k] <= '0;
        end else begin
            mpipe[0] <= DW'(modmul(int'(mul_a), int'(mul_b)));
            for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign mul_p = mpipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int exp_inflight();
        int n = 0;
        foreach (issue_log[i]) begin
            if (issue_log[i] >= cyc - LAT && issue_log[i] <= cyc - 1) n++;
        end
        return n;
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*DW +: DW] = DW'(a);
        req_b[i*DW +: DW] = DW'(b);
    endtask

    // One clock cycle: predict the grant, check it at negedge, record the expected response.
    task automatic step();
        int            g;
        int            ea;
        int            eb;
        logic [NR-1:0] exp_ready;
        g  = -1;
        ea = 0;
        eb = 0;
        exp_ready = '0;
        if (!hold) begin
            for (int i = 0; i < NR; i++) begin
                int idx;
                idx = (ptr_m + i) % NR;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            ea = int'(req_a[g*DW +: DW]);
            eb = int'(req_b[g*DW +: DW]);
        end
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("mul_a", 32'(mul_a), 32'(ea));
        check("mul_b", 32'(mul_b), 32'(eb));
        check("inflight", 32'(inflight), 32'(exp_inflight()));
        if (g >= 0) begin
            sb.push_back('{g, modmul(ea, eb), cyc + LAT});
            issue_log.push_back(cyc);
            ptr_m = (g + 1) % NR;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_mul_a"}, 32'(mul_a), 32'd0);
        check({tag, "_mul_b"}, 32'(mul_b), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_data"}, 32'(resp_data), 32'd0);
        check({tag, "_inflight"}, 32'(inflight), 32'd0);
    endtask

    task automatic model_reset();
        sb.delete();
        issue_log.delete();
        ptr_m = 0;
    endtask

    // Response monitor: a due entry must appear exactly on its cycle; otherwise outputs stay quiet.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                check("resp_valid", 32'(resp_valid), 32'(1 << mon_e.id));
                check("resp_data", 32'(resp_data), 32'(mon_e.data));
            end else begin
                check("resp_idle", {14'd0, resp_valid, resp_data}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion by 100000, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a_t [4];
        int b_t [4];
        a_t = '{12288, 2, 12288, 0};
        b_t = '{12288, 6145, 1, 7};
        hold      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        // Asynchronous reset with live requests: everything reads 0 before any edge.
        #1 rst = 1'b1;
        model_reset();
        req_valid = '1;
        for (int i = 0; i < NR; i++) set_op(i, 100 + i, 200 + i);
        #2 check_all_zero("reset");
        req_valid = '0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single op on requester 2: 3*5 returns 15 four cycles later.
        set_op(2, 3, 5);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (5) step();

        // Modular boundaries back-to-back on requester 0.
        req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            set_op(0, a_t[k], b_t[k]);
            step();
        end
        req_valid = '0;
        repeat (5) step();

        // Park the pointer at 0, then all four contend for 8 cycles.
        set_op(3, 9, 11);
        req_valid = 4'b1000;
        step();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NR; i++) set_op(i, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
            step();
        end
        req_valid = '0;
        repeat (5) step();

        // Only requester 0 valid with ptr at 1: granted through the wrap.
        set_op(0, 1234, 5678);
        req_valid = 4'b0001;
        step();
        set_op(0, 4321, 8765);
        step();
        // Hold with results in flight: no grants, earlier results still land.
        hold = 1'b1;
        req_valid = 4'b1111;
        repeat (2) step();
        hold = 1'b0;
        req_valid = '0;
        step();
        set_op(2, 77, 88);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (5) step();

        // Reset mid-flight: three ops discarded, then a fresh op returns cleanly.
        set_op(1, 111, 222);
        req_valid = 4'b0010;
        step();
        set_op(2, 333, 444);
        req_valid = 4'b0100;
        step();
        set_op(3, 555, 666);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        check("pre_reset_resp_valid", 32'(resp_valid), 32'(1 << sb[0].id));
        check("pre_reset_resp_data", 32'(resp_data), 32'(sb[0].data));
        rst = 1'b1;
        model_reset();
        #1 check_all_zero("midflight_reset");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (6) step();
        set_op(1, 100, 200);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        repeat (6) step();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/modmul_arbiter.md
Name: modmul_arbiter

Overview:
- Shares one fixed-latency Barrett modular multiplier (q = 12289, 14-bit operands, 4-cycle latency, no stall input) between num_req independent requesters.
- Arbitrates round-robin, drives the multiplier operands, and carries a requester tag through a shift pipeline matched to the multiplier latency.
- Returns each product as a one-cycle pulse to the requester that issued it.
- Sits between the NTT butterfly/pointwise-multiply sequencers and the shared multiplier instance.

Parameters:
- data_width, 14, operand/result width
- num_req, 4, number of requesters (2..8)
- mul_latency, 4, clock edges from operand presentation to valid mul_p
- id_width, 2, requester index width, equal to clog2(num_req)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  num_req  per-requester operation request
- req_a  input  num_req*data_width  packed operand A; requester i occupies bits [i*data_width +: data_width]
- req_b  input  num_req*data_width  packed operand B, same packing as req_a
- req_ready  output  num_req  one-hot grant; a handshake on i is req_valid[i] & req_ready[i]
- hold  input  1  when 1, no grant is issued this cycle
- mul_a  output  data_width  operand A to the multiplier
- mul_b  output  data_width  operand B to the multiplier
- mul_p  input  data_width  multiplier result, already reduced mod q
- resp_valid  output  num_req  one-hot result strobe
- resp_data  output  data_width  result, valid while any resp_valid bit is set
- inflight  output  3  number of accepted operations not yet returned (0..mul_latency)

Behaviour:
- Reset (asynchronous, active-high), all of the following clear immediately:
  - req_ready = 0, resp_valid = 0, resp_data = 0, inflight = 0
  - round-robin pointer = 0, all tag-pipeline stages invalid
  - mul_a and mul_b read 0 while rst is asserted
- Arbitration (combinational, every cycle):
  - Candidates are req_valid bits, searched from index ptr upward with wrap.
  - The first set bit is granted and req_ready is one-hot on it.
  - No grant when hold = 1 or when no req_valid bit is set.
  - At most one grant per cycle.
- Pointer update (registered): on a grant to index g, ptr <= (g+1) mod num_req. Otherwise ptr is unchanged.
- Operand drive:
  - mul_a/mul_b carry the granted requester's req_a/req_b slice in the same cycle.
  - With no grant they are driven to 0, so the multiplier computes 0.
- Tag pipeline:
  - mul_latency stages, each holding {valid, id}.
  - Stage 0 loads {grant_any, g} on every edge; stage k loads stage k-1.
  - The last stage aligns with mul_p.
- Response:
  - Registered output: resp_valid[id_last] = valid_last, resp_data = mul_p when valid_last, else 0.
  - A handshake in cycle t produces resp_valid and resp_data in cycle t+mul_latency, i.e. 4 cycles later.
  - Back-to-back issue gives one result per cycle, in issue order.
- Throughput: one operation per cycle. No response back-pressure, so requesters must accept resp_valid pulses unconditionally.
- inflight:
  - Increments on a handshake, decrements on the cycle resp_valid is asserted.
  - Unchanged when both occur in the same cycle.
  - Never exceeds mul_latency.
- Boundary cases:
  - req_valid dropped without a grant: the request is withdrawn, with no side effect.
  - hold asserted with operations in flight: pending results still return on schedule.
  - Reset mid-operation: in-flight operations are discarded with no resp_valid. The multiplier shares rst, so no stale result can appear later.
  - Single requester asserted continuously: it is granted every cycle; ptr advances past it and wraps back.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> every output is 0 before the next edge; inflight = 0.
- Single op on requester 2: issue a=3, b=5 at cycle t -> resp_valid = 4'b0100 with resp_data = 15 at t+4; no other strobes; inflight goes 1 during t+1..t+4, then 0.
- Modular boundaries, back-to-back on requester 0:
  - 12288*12288 -> 1
  - 2*6145 -> 1
  - 12288*1 -> 12288
  - 0*7 -> 0
  - Expect four consecutive resp pulses at t+4..t+7 with exactly those values, in order.
- Round-robin fairness: all four req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each response is tagged to the matching requester 4 cycles after its grant.
- Hold and sparse requests, in sequence:
  - Step 1: ptr = 1 with only requester 0 valid -> 0 is granted (wrap).
  - Step 2: hold = 1 for 2 cycles -> req_ready = 0 and no new inflight increments; prior results still arrive on schedule.
- Reset mid-flight: issue 3 ops, assert rst 2 cycles later -> no resp_valid afterward. A new op after release returns correctly 4 cycles after its issue.
